// File: rtl/islemci_denetim_if.sv
// Instruction-memory fetch handshake between the control sequencer and the memory.
interface islemci_denetim_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/islemci_denetim.sv
// Multi-cycle control sequencer: owns pc/instruction register, sequences
// fetch/decode/execute/writeback and parks in a sticky HALT on any fault.
module islemci_denetim #(
  parameter logic [31:0] PC_RESET      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     calis,
  islemci_denetim_if.master        imem,
  output logic [31:0]              komut,
  input  logic [6:0]               opcode,
  input  logic [31:0]              imm,
  input  logic                     hata,
  input  logic                     br_taken,
  output logic                     alu_en,
  output logic                     rf_we,
  output logic [31:0]              pc,
  output logic [2:0]               durum,
  output logic [1:0]               hata_kodu,
  output logic [31:0]              komut_sayaci
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_e;

  localparam logic [6:0]  OP_B    = 7'b0001111;
  localparam logic [15:0] TO_LAST = 16'(FETCH_TIMEOUT - 1);
  localparam logic        TO_EN   = (FETCH_TIMEOUT != 0);

  state_e      r_state, w_state_n;
  logic [31:0] r_pc, r_komut, r_sayac;
  logic [1:0]  r_kod;
  logic [15:0] r_tout;

  logic [31:0] w_target;
  logic        w_is_b, w_misalign, w_tout_hit;

  assign w_target   = r_pc + imm;
  assign w_is_b     = (opcode == OP_B);
  assign w_misalign = (w_target[1:0] != 2'b00);
  assign w_tout_hit = TO_EN && (r_tout == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:      if (calis) w_state_n = FETCH;
      FETCH: begin
        if (imem.imem_valid)  w_state_n = DECODE;
        else if (w_tout_hit)  w_state_n = HALT;
      end
      DECODE:    w_state_n = hata ? HALT : EXECUTE;
      EXECUTE: begin
        if (w_is_b) w_state_n = (br_taken && w_misalign) ? HALT : FETCH;
        else        w_state_n = WRITEBACK;
      end
      WRITEBACK: w_state_n = FETCH;
      HALT:      w_state_n = HALT;
      default:   w_state_n = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = 1'b0;
    alu_en        = 1'b0;
    rf_we         = 1'b0;
    case (r_state)
      FETCH:     imem.imem_req = 1'b1;
      EXECUTE:   alu_en        = 1'b1;
      WRITEBACK: rf_we         = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers follow the state being left, so every update lands on
  // the same edge as the corresponding state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= PC_RESET;
      r_komut <= '0;
      r_sayac <= '0;
      r_kod   <= '0;
      r_tout  <= '0;
    end else begin
      if (r_state != FETCH && w_state_n == FETCH) r_tout <= '0;
      else if (r_state == FETCH)                   r_tout <= r_tout + 16'd1;

      case (r_state)
        FETCH: begin
          if (imem.imem_valid) r_komut <= imem.imem_rdata;
          else if (w_tout_hit) r_kod   <= 2'd2;
        end
        DECODE: if (hata) r_kod <= 2'd1;
        EXECUTE: begin
          if (w_is_b) begin
            if (!br_taken) begin
              r_pc    <= r_pc + 32'd4;
              r_sayac <= r_sayac + 32'd1;
            end else if (w_misalign) begin
              r_kod   <= 2'd3;
            end else begin
              r_pc    <= w_target;
              r_sayac <= r_sayac + 32'd1;
            end
          end
        end
        WRITEBACK: begin
          r_pc    <= r_pc + 32'd4;
          r_sayac <= r_sayac + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem.imem_addr = r_pc;
  assign pc             = r_pc;
  assign komut          = r_komut;
  assign komut_sayaci   = r_sayac;
  assign hata_kodu      = r_kod;
  assign durum          = r_state;

endmodule

// File: tb/tb_islemci_denetim.sv
// Directed table-driven bench for islemci_denetim; the bench plays memory and decoder.
module tb_islemci_denetim;

  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;
  localparam logic [6:0] OP_X = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        calis = 1'b0;
  logic [31:0] komut, pc, komut_sayaci, imm_r;
  logic [6:0]  opcode;
  logic        hata, br_r, alu_en, rf_we;
  logic [2:0]  durum;
  logic [1:0]  hata_kodu;

  int n_chk = 0;
  int n_err = 0;

  islemci_denetim_if ifc ();

  islemci_denetim #(.PC_RESET(32'h0000_0100), .FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .calis(calis), .imem(ifc.master),
    .komut(komut), .opcode(opcode), .imm(imm_r), .hata(hata), .br_taken(br_r),
    .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .durum(durum),
    .hata_kodu(hata_kodu), .komut_sayaci(komut_sayaci)
  );

  // Combinational decoder model: opcode is the low 7 bits of the instruction.
  assign opcode = komut[6:0];
  assign hata   = !(opcode inside {OP_R, OP_I, OP_U, OP_B});

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  op;
    logic [31:0] imm;
    logic        br;
    int          wt;
    logic        rst;
    int          cyc;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [1:0]  kod;
    int          we;
    int          alu;
    int          req;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic reset_start();
    rst_n = 1'b0; calis = 1'b0; ifc.imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    calis = 1'b1;
    @(negedge clk);
    calis = 1'b0;
  endtask

  // Runs one instruction from a FETCH cycle until the next FETCH or HALT.
  task automatic run_instr(input vec_t v, output int cyc, output int nwe,
                           output int nalu, output int nreq);
    int  w = 0;
    bit  left = 0;
    bit  done = 0;
    cyc = 0; nwe = 0; nalu = 0; nreq = 0;
    imm_r = v.imm; br_r = v.br;
    ifc.imem_rdata = {25'h0, v.op};
    for (int k = 0; k < 64 && !done; k++) begin
      if (ifc.imem_req) nreq++;
      if (alu_en) nalu++;
      if (rf_we)  nwe++;
      if (durum == 3'd1) begin
        ifc.imem_valid = (w == v.wt);
        w++;
      end else begin
        ifc.imem_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (durum != 3'd1) left = 1;
      if (durum == 3'd5 || (left && durum == 3'd1)) done = 1;
    end
    ifc.imem_valid = 1'b0;
    if (!done) chk("instr_bound", 32'(cyc), 32'd0);
  endtask

  task automatic run_range(input int lo, input int hi);
    int cyc, nwe, nalu, nreq;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].rst) reset_start();
      run_instr(tbl[i], cyc, nwe, nalu, nreq);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("v%0d_addr", i), ifc.imem_addr, tbl[i].pc);
      chk($sformatf("v%0d_count", i), komut_sayaci, tbl[i].cnt);
      chk($sformatf("v%0d_kod", i), 32'(hata_kodu), 32'(tbl[i].kod));
      chk($sformatf("v%0d_rf_we", i), 32'(nwe), 32'(tbl[i].we));
      chk($sformatf("v%0d_alu_en", i), 32'(nalu), 32'(tbl[i].alu));
      chk($sformatf("v%0d_req", i), 32'(nreq), 32'(tbl[i].req));
      chk($sformatf("v%0d_durum", i), 32'(durum), 32'(tbl[i].st));
    end
  endtask

  initial begin
    logic [2:0] seq [4];
    int nwe, nstb, cyc, nalu, nreq;

    //        op    imm           br  wt  rst cyc pc            cnt kod we alu req st
    tbl[0]  = '{OP_I, 32'h0,        0, 0,  0, 4, 32'h0000_0108, 2,  0, 1, 1, 1, 1};
    tbl[1]  = '{OP_U, 32'h0,        0, 2,  0, 6, 32'h0000_010C, 3,  0, 1, 1, 3, 1};
    tbl[2]  = '{OP_B, 32'hF4,       1, 0,  0, 3, 32'h0000_0200, 4,  0, 0, 1, 1, 1};
    tbl[3]  = '{OP_B, 32'h10,       1, 0,  0, 3, 32'h0000_0210, 5,  0, 0, 1, 1, 1};
    tbl[4]  = '{OP_B, 32'hFFFF_FFF0,1, 0,  0, 3, 32'h0000_0200, 6,  0, 0, 1, 1, 1};
    tbl[5]  = '{OP_B, 32'h10,       0, 0,  0, 3, 32'h0000_0204, 7,  0, 0, 1, 1, 1};
    tbl[6]  = '{OP_B, 32'hFFFF_FFFC,1, 0,  0, 3, 32'h0000_0200, 8,  0, 0, 1, 1, 1};
    tbl[7]  = '{OP_R, 32'h0,        0, 3,  0, 7, 32'h0000_0204, 9,  0, 1, 1, 4, 1};
    tbl[8]  = '{OP_B, 32'hFFFF_FDF8,1, 0,  0, 3, 32'hFFFF_FFFC, 10, 0, 0, 1, 1, 1};
    tbl[9]  = '{OP_I, 32'h0,        0, 0,  0, 4, 32'h0000_0000, 11, 0, 1, 1, 1, 1};
    tbl[10] = '{OP_B, 32'h200,      1, 0,  0, 3, 32'h0000_0200, 12, 0, 0, 1, 1, 1};
    tbl[11] = '{OP_B, 32'h6,        1, 0,  0, 3, 32'h0000_0200, 12, 3, 0, 1, 1, 5};
    tbl[12] = '{OP_X, 32'h0,        0, 0,  1, 2, 32'h0000_0100, 0,  1, 0, 0, 1, 5};
    tbl[13] = '{OP_R, 32'h0,        0, 99, 1, 4, 32'h0000_0100, 0,  2, 0, 0, 4, 5};

    ifc.imem_valid = 1'b0; ifc.imem_rdata = '0; imm_r = '0; br_r = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_durum", 32'(durum), 32'd0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_addr", ifc.imem_addr, 32'h100);
    chk("rst_komut", komut, 32'h0);
    chk("rst_count", komut_sayaci, 32'h0);
    chk("rst_kod", 32'(hata_kodu), 32'd0);
    chk("rst_strobes", {29'h0, ifc.imem_req, alu_en, rf_we}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", 32'(durum), 32'd0);
    calis = 1'b1;
    @(negedge clk);
    calis = 1'b0;
    chk("fetch_entry", 32'(durum), 32'd1);
    chk("fetch_req", 32'(ifc.imem_req), 32'd1);

    // First R instruction: durum 1,2,3,4,1 with a single rf_we pulse.
    ifc.imem_valid = 1'b1; ifc.imem_rdata = {25'h0, OP_R};
    nwe = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      ifc.imem_valid = 1'b0;
      seq[k] = durum;
      if (rf_we) nwe++;
    end
    chk("seq_d", 32'(seq[0]), 32'd2);
    chk("seq_e", 32'(seq[1]), 32'd3);
    chk("seq_w", 32'(seq[2]), 32'd4);
    chk("seq_f", 32'(seq[3]), 32'd1);
    chk("first_rf_we", 32'(nwe), 32'd1);
    chk("first_pc", pc, 32'h104);
    chk("first_count", komut_sayaci, 32'd1);

    run_range(0, 11);

    // Sticky HALT: calis and imem_valid must not disturb anything.
    nstb = 0;
    for (int k = 0; k < 6; k++) begin
      calis = k[0];
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      if (ifc.imem_req || alu_en || rf_we) nstb++;
      chk($sformatf("halt_hold%0d", k), 32'(durum), 32'd5);
    end
    calis = 1'b0; ifc.imem_valid = 1'b0;
    chk("halt_strobes", 32'(nstb), 32'd0);
    chk("halt_pc", pc, 32'h200);
    chk("halt_count", komut_sayaci, 32'd12);
    chk("halt_kod", 32'(hata_kodu), 32'd3);
    chk("halt_komut", komut, {25'h0, OP_B});

    run_range(12, 13);

    // Asynchronous reset in EXECUTE after one retired instruction.
    reset_start();
    run_instr('{OP_R, 32'h0, 1'b0, 0, 1'b0, 0, 32'h0, 32'h0, 2'd0, 0, 0, 0, 3'd0},
              cyc, nwe, nalu, nreq);
    chk("arst_pre_count", komut_sayaci, 32'd1);
    ifc.imem_valid = 1'b1; ifc.imem_rdata = {25'h0, OP_R};
    @(negedge clk);
    ifc.imem_valid = 1'b0;
    @(negedge clk);
    chk("arst_in_exec", 32'(durum), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_durum", 32'(durum), 32'd0);
    chk("arst_pc", pc, 32'h100);
    chk("arst_count", komut_sayaci, 32'd0);
    chk("arst_komut", komut, 32'h0);
    chk("arst_strobes", {29'h0, ifc.imem_req, alu_en, rf_we}, 32'h0);
    nwe = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) rst_n = 1'b1;
      @(posedge clk); #1;
      if (rf_we) nwe++;
    end
    chk("arst_no_rf_we", 32'(nwe), 32'd0);
    chk("arst_idle", 32'(durum), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/islemci_denetim.md
# islemci_denetim

Multi-cycle control sequencer for the processor datapath. Owns the program counter and instruction register, fetches instructions over a req/valid memory handshake, presents them to the instruction decoder, then strobes the ALU and register-file write in sequence. Decoder error flags, fetch timeouts and misaligned branch targets stop the core in a sticky halt state.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, maximum FETCH cycles without imem_valid before halting (1..65535); 0 disables the timeout.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- calis  input  1  run request; sampled only in IDLE.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address; equals pc.
- imem_valid  input  1  fetch data valid.
- imem_rdata  input  32  fetched instruction word.
- komut  output  32  instruction register, driven to the decoder.
- opcode  input  7  decoder opcode. R=7'b0000001, I=7'b0000011, U=7'b0000111, B=7'b0001111.
- imm  input  32  decoder immediate, used as the branch offset.
- hata  input  1  decoder illegal-opcode flag.
- br_taken  input  1  branch comparison result from the ALU; valid in EXECUTE.
- alu_en  output  1  ALU operate strobe.
- rf_we  output  1  register-file write enable.
- pc  output  32  program counter.
- durum  output  3  state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- hata_kodu  output  2  halt cause: 0 none, 1 illegal opcode, 2 fetch timeout, 3 misaligned branch target.
- komut_sayaci  output  32  retired-instruction count; wraps modulo 2^32.

## Operation
- Reset values: pc=PC_RESET, komut=0, durum=IDLE, hata_kodu=0, komut_sayaci=0, timeout counter=0. imem_req, alu_en and rf_we are 0.
- imem_req, alu_en and rf_we are Moore outputs decoded from durum only. imem_addr=pc at all times.
- IDLE: if calis=1, go to FETCH and clear the timeout counter. Otherwise stay in IDLE.
- FETCH: imem_req=1, and pc is held stable until imem_valid.
  - imem_valid=1: komut<=imem_rdata, go to DECODE.
  - No valid and counter==FETCH_TIMEOUT-1 (FETCH_TIMEOUT≠0): go to HALT with hata_kodu=2.
  - Otherwise increment the counter.
  - imem_valid is ignored in all other states.
- DECODE: one cycle; the decoder is combinational on komut.
  - hata=1: go to HALT with hata_kodu=1; pc and komut_sayaci are unchanged.
  - Otherwise go to EXECUTE.
- EXECUTE: alu_en=1 for one cycle.
  - opcode=B, br_taken=1: target=pc+imm (32-bit, wrapping).
    - If target[1:0]≠0: go to HALT with hata_kodu=3; pc is unchanged and the instruction is not retired.
    - Otherwise pc<=target, komut_sayaci++, go to FETCH.
  - opcode=B, br_taken=0: pc<=pc+4, komut_sayaci++, go to FETCH.
  - opcode R/I/U: go to WRITEBACK.
- WRITEBACK: rf_we=1 for one cycle; pc<=pc+4, komut_sayaci++, go to FETCH.
- Every entry into FETCH clears the timeout counter.
- PC arithmetic wraps modulo 2^32: 32'hFFFF_FFFC+4 gives 0.
- HALT: terminal. All strobes are 0; pc, komut, hata_kodu and komut_sayaci are frozen. Exit is by reset only. calis is ignored outside IDLE.
- Reset asserted mid-instruction: all registers return to their reset values immediately. No strobe is emitted after rst_n falls.

## Timing
- Latency per instruction, with imem_valid on the first FETCH cycle: R/I/U take 4 cycles (F,D,E,W); B takes 3 cycles (F,D,E).
- Each FETCH wait cycle adds 1 cycle.
- pc and komut_sayaci update on the clock edge that leaves EXECUTE (B) or WRITEBACK (R/I/U). The new pc appears on imem_addr in the first cycle of the next FETCH.
- komut updates on the edge that leaves FETCH and is stable through DECODE, EXECUTE and WRITEBACK.
- Halt entry: hata_kodu and durum=HALT are visible in the cycle after the faulting state.

## Test plan
- Reset with PC_RESET=32'h100, calis=1, R instruction returned with valid in the same cycle -> durum sequence 0,1,2,3,4,1; rf_we high exactly 1 cycle; pc=32'h104; komut_sayaci=1.
- B instruction at pc=32'h200, imm=32'h10, br_taken=1 -> no rf_we pulse; next imem_addr=32'h210 after 3 cycles. Same with br_taken=0 -> next imem_addr=32'h204.
- B instruction at pc=32'h200, imm=32'h6, br_taken=1 -> HALT, hata_kodu=3, pc stays 32'h200, komut_sayaci unchanged. calis toggling has no effect until reset.
- Instruction with opcode 7'b1111111 and decoder hata=1 -> HALT from DECODE, hata_kodu=1, alu_en never asserted.
- FETCH_TIMEOUT=4, imem_valid held low -> exactly 4 FETCH cycles with imem_req=1, then HALT with hata_kodu=2. Repeat with valid on the 4th cycle -> no halt, DECODE follows.
- pc=32'hFFFF_FFFC executing an I instruction -> pc wraps to 0. Assert rst_n=0 during EXECUTE -> outputs return to reset values asynchronously and no rf_we pulse appears.
